// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the instruction FIFO. Holds the PC, issues
//   one instruction-memory request at a time (req/gnt, then rvalid), and pushes
//   each {pc, instr} pair into the FIFO. A redirect replaces the PC and causes
//   any response still in flight to be discarded.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            synchronous active-low reset
//   fetch_en         allows a new request to be started from IDLE
//   redirect_valid   single-cycle redirect strobe
//   redirect_pc      redirect target (bits [1:0] forced to zero)
//   imem_req         request valid (high exactly while in REQ)
//   imem_addr        request address, always the current PC
//   imem_gnt         memory accepted the request this cycle
//   imem_rvalid      response valid, at least one cycle after the grant
//   imem_rdata       response instruction word
//   fifo_full        full flag of the downstream instruction FIFO
//   fifo_write_en    registered one-cycle push strobe
//   fifo_write_data  registered {pc, instr}, holds its value between pushes
//   busy             high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter int               ILEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [ILEN-1:0]      imem_rdata,
  input  logic                 fifo_full,
  output logic                 fifo_write_en,
  output logic [XLEN+ILEN-1:0] fifo_write_data,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] PC_ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      w_pc_nxt;
  logic [XLEN-1:0]      w_redirect_pc;
  logic                 w_push;
  logic                 r_fifo_we;
  logic [XLEN+ILEN-1:0] r_fifo_wdata;

  // Redirect targets are always word aligned.
  assign w_redirect_pc = redirect_pc & PC_ALIGN;

  // Next-state, next-PC and push decision for the fetch FSM
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
        end else if (fetch_en && !fifo_full && !r_fifo_we) begin
          // r_fifo_we covers a push the FIFO full flag cannot show yet.
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
          // Granted together with a redirect: the response is stale.
          w_state_nxt = imem_gnt ? S_DROP : S_IDLE;
        end else if (imem_gnt) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // Redirect wins over a response arriving in the same cycle.
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = imem_rvalid ? S_IDLE : S_DROP;
        end else if (imem_rvalid) begin
          w_push      = 1'b1;
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
        // The stale response ends the transaction even if a redirect arrives.
        if (imem_rvalid) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state, PC and registered FIFO push outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_fifo_we    <= 1'b0;
      r_fifo_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_fifo_we <= w_push;
      if (w_push) begin
        r_fifo_wdata <= {r_pc, imem_rdata};
      end else begin
        r_fifo_wdata <= r_fifo_wdata;
      end
    end
  end

  assign imem_req        = (r_state == S_REQ);
  assign imem_addr       = r_pc;
  assign busy            = (r_state != S_IDLE);
  assign fifo_write_en   = r_fifo_we;
  assign fifo_write_data = r_fifo_wdata;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        fifo_full = 1'b0;
  logic        fifo_write_en;
  logic [63:0] fifo_write_data;
  logic        busy;

  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_write_data(fifo_write_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [63:0] exp_q[$];

  // Reference model: architectural PC plus one outstanding memory transaction.
  logic [31:0] m_pc = RST_PC;
  bit  mem_busy = 0, mem_stale = 0, mem_orphan = 0;
  int  mem_cnt = 0;
  // Stimulus knobs
  logic fe = 1'b0;
  int  gnt_mode = 0;          // 0 always grant, 1 random, 2 never
  int  dly_min = 1, dly_max = 1;
  bit  spur_en = 0, seq_data = 0, chk_spacing = 0;
  int  data_seq = 0;
  int  force_full = 0;        // -1: FIFO model drives full, 0/1 forced
  int  fifo_cnt = 0, fifo_cap = 2, pop_pct = 100;
  int  cyc = 0, last_req_cyc = -1;
  bit  prev_req = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: observe outputs, act as memory and FIFO, update the model.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic rst);
    logic        gnt, rv, full;
    logic [31:0] rdata;
    bit          pop;
    @(negedge clk);
    cyc++;
    if (imem_req === 1'b1) begin
      check("imem_addr", imem_addr, m_pc);
      check("req_while_outstanding", mem_busy, 1'b0);
    end
    check("busy", busy, imem_req || (mem_busy && !mem_orphan));
    if (imem_req && !prev_req) begin
      if (chk_spacing && last_req_cyc >= 0) check("req_spacing", cyc - last_req_cyc, 4);
      last_req_cyc = cyc;
    end
    prev_req = imem_req;
    // downstream FIFO
    if (force_full >= 0) begin
      full = force_full[0];
    end else begin
      full = (fifo_cnt >= fifo_cap);
      pop  = (fifo_cnt > 0) && ($urandom_range(99) < pop_pct);
      if (pop) fifo_cnt--;
      if (fifo_write_en) begin
        check("fifo_overflow", fifo_cnt < fifo_cap, 1'b1);
        fifo_cnt++;
      end
    end
    // memory responder
    rv = 1'b0;
    rdata = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) rv = 1'b1;
      if (rv && seq_data) begin
        rdata = 32'h13 + 32'h80 * data_seq;
        data_seq++;
      end
    end else if (spur_en && $urandom_range(3) == 0) begin
      rv = 1'b1;
    end
    if (rst) gnt = 1'b0;
    else if (imem_req && !mem_busy) gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    else if (imem_req) gnt = 1'b0;
    else gnt = 1'($urandom_range(1));
    // model update for the coming edge
    if (rv && mem_busy) begin
      if (!mem_stale && !rd && !rst) begin
        exp_q.push_back({m_pc, rdata});
        m_pc = m_pc + 32'd4;
      end
      mem_busy = 0;
      mem_orphan = 0;
    end
    if (imem_req && gnt) begin
      mem_busy = 1;
      mem_stale = 0;
      mem_orphan = 0;
      mem_cnt = $urandom_range(dly_max, dly_min);
    end
    if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      if (mem_busy) mem_stale = 1;
    end
    if (rst) begin
      m_pc = RST_PC;
      if (mem_busy) begin
        mem_stale = 1;
        mem_orphan = 1;
      end
    end
    reset = !rst;
    fetch_en = fe;
    redirect_valid = rd;
    redirect_pc = rpc;
    imem_gnt = gnt;
    imem_rvalid = rv;
    imem_rdata = rdata;
    fifo_full = full;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    check(nm, imem_req, 1'b1);
  endtask

  task automatic wait_grant(input string nm);
    int n = 0;
    while (!mem_busy && n < 40) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    check(nm, mem_busy, 1'b1);
  endtask

  // Scoreboard monitor: every push must match the oldest expected pair.
  always @(negedge clk) begin
    if (fifo_write_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push: got %h, expected no push", fifo_write_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (fifo_write_data !== e) begin
          errors++;
          $display("FAIL push_data: got %h, expected %h", fifo_write_data, e);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_we", fifo_write_en, 1'b0);
    check("rst_data", fifo_write_data, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", imem_addr, RST_PC);

    // Back-to-back fetch with a one-cycle memory, crossing the PC wrap
    fe = 1'b1; seq_data = 1; chk_spacing = 1;
    repeat (22) step(1'b0, 32'h0, 1'b0);
    seq_data = 0; chk_spacing = 0;

    // Forced full flag blocks issue; release gives a request next cycle
    force_full = 1;
    repeat (8) step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check("req_while_full", imem_req, 1'b0);
    end
    force_full = 0;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("req_after_full", imem_req, 1'b1);

    // One-entry FIFO that never drains: the push itself must block issue
    repeat (8) step(1'b0, 32'h0, 1'b0);
    force_full = -1; fifo_cnt = 0; fifo_cap = 1; pop_pct = 0;
    repeat (16) step(1'b0, 32'h0, 1'b0);
    check("hold_full_idle", busy, 1'b0);
    pop_pct = 100; fifo_cap = 2;
    repeat (4) step(1'b0, 32'h0, 1'b0);

    // Redirect while waiting: stale response dropped, fetch from 0x100
    dly_min = 3; dly_max = 3;
    wait_grant("t3_grant");
    step(1'b1, 32'h100, 1'b0);
    wait_req("t3_req");
    check("t3_addr", imem_addr, 32'h100);
    repeat (6) step(1'b0, 32'h0, 1'b0);

    // Redirect coincident with rvalid, then redirect withdrawing a request
    dly_min = 2; dly_max = 2;
    wait_grant("t4_grant");
    n = 0;
    while (!(mem_busy && mem_cnt == 1) && n < 10) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    step(1'b1, 32'h200, 1'b0);
    gnt_mode = 2;
    wait_req("t4_req");
    check("t4_addr", imem_addr, 32'h200);
    step(1'b1, 32'h203, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("t4_withdrawn", imem_req, 1'b0);
    gnt_mode = 0;
    wait_req("t4_req2");
    check("t4_addr2", imem_addr, 32'h200);
    repeat (6) step(1'b0, 32'h0, 1'b0);

    // Reset while waiting: outputs clear, late response ignored, restart
    dly_min = 6; dly_max = 6;
    wait_grant("t6_grant");
    step(1'b0, 32'h0, 1'b0);
    fe = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    check("t6_req", imem_req, 1'b0);
    check("t6_we", fifo_write_en, 1'b0);
    check("t6_data", fifo_write_data, 64'h0);
    check("t6_busy", busy, 1'b0);
    check("t6_addr", imem_addr, RST_PC);
    n = 0;
    while (mem_busy && n < 20) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    check("t6_drain", mem_busy, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    fe = 1'b1; dly_min = 1; dly_max = 1;
    wait_req("t6_req_restart");
    check("t6_restart_addr", imem_addr, RST_PC);
    repeat (10) step(1'b0, 32'h0, 1'b0);

    // Randomised traffic
    gnt_mode = 1; dly_min = 1; dly_max = 4; spur_en = 1;
    force_full = -1; fifo_cnt = 0; fifo_cap = 2; pop_pct = 50;
    for (int i = 0; i < 2000; i++) begin
      fe = ($urandom_range(9) != 0);
      step(($urandom_range(14) == 0), $urandom, 1'b0);
    end

    // Drain outstanding work and confirm every expected push appeared
    fe = 1'b0; gnt_mode = 0; spur_en = 0; pop_pct = 100;
    repeat (20) step(1'b0, 32'h0, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
